// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe
// Pipelined Wallace-tree multiplier producing the full 2W-bit product of two
// W-bit operands, unsigned or two's-complement per operation.
//
// Parameters:
//   W       operand width (4..16)
//   STAGES  register stages from accepted input to registered prod (1..4)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ena          design enable; low freezes every register
//   in_valid     operand pair present
//   in_ready     operands accepted this cycle
//   a, b         multiplicand / multiplier (W bits)
//   signed_mode  1 = two's-complement operands, sampled with a/b
//   out_valid    prod holds a result
//   out_ready    consumer takes the result this cycle
//   prod         registered 2W-bit product
//   acc_en       (WALLACE_ACC_EN only) add this product to the running sum
//
// Optional feature macro: WALLACE_ACC_EN adds acc_en and a 2W-bit
// accumulator. An op with acc_en=1 outputs acc + product; acc_en=0 outputs
// the plain product and restarts the sum from it.
//
// Pipeline: stage 1 registers the operands; the word-level 3:2 reduction
// levels are cut by STAGES-2 evenly spaced register ranks; the final
// carry-propagate adder feeds the prod register. All stages advance
// together (global stall), bubbles included.
module wallace_mult_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_mode,
`ifdef WALLACE_ACC_EN
  input  logic           acc_en,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod
);

  localparam int PW  = 2 * W;
  localparam int NR0 = W + 1;  // W partial-product rows plus the correction row

  function automatic int next_rows(input int n);
    return (n > 2) ? (2 * (n / 3) + (n % 3)) : n;
  endfunction

  function automatic int rows_at(input int l);
    int n;
    n = NR0;
    for (int i = 0; i < l; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int count_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  localparam int L    = count_levels(NR0);
  localparam int NCUT = (STAGES > 2) ? (STAGES - 2) : 0;

  // L >= 3 for every legal W and NCUT <= 2, so the cut points land on
  // distinct levels strictly inside the tree.
  function automatic bit is_cut(input int l);
    bit hit;
    hit = 1'b0;
    for (int p = 1; p <= NCUT; p++)
      if (l == (p * L) / (NCUT + 1)) hit = 1'b1;
    return hit;
  endfunction

  // Baugh-Wooley correction: +2^W + 2^(2W-1) absorbs the inverted sign terms.
  localparam logic [PW-1:0] BW_K = (PW'(1) << W) | (PW'(1) << (PW - 1));

`ifdef WALLACE_ACC_EN
  localparam int TW = 2;  // {acc_en, valid}
`else
  localparam int TW = 1;  // {valid}
`endif

  logic advance;
  assign advance  = ena & ~(out_valid & ~out_ready);
  assign in_ready = advance & rst_n;

  logic [TW-1:0] tag_in;
`ifdef WALLACE_ACC_EN
  assign tag_in = {acc_en, in_valid & in_ready};
`else
  assign tag_in = in_valid & in_ready;
`endif

  // Operand stage (bypassed when the only register is prod itself).
  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic          m_s;
  logic [TW-1:0] tag_s;

  genvar gi;
  generate
    if (STAGES > 1) begin : g_in_reg
      logic [W-1:0]  a_q;
      logic [W-1:0]  b_q;
      logic          m_q;
      logic [TW-1:0] tag_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          m_q   <= 1'b0;
          tag_q <= '0;
        end else if (advance) begin
          a_q   <= a;
          b_q   <= b;
          m_q   <= signed_mode;
          tag_q <= tag_in;
        end
      end
      assign a_s   = a_q;
      assign b_s   = b_q;
      assign m_s   = m_q;
      assign tag_s = tag_q;
    end else begin : g_in_comb
      assign a_s   = a;
      assign b_s   = b;
      assign m_s   = signed_mode;
      assign tag_s = tag_in;
    end
  endgenerate

  // Partial products; in signed mode the terms that carry a single sign bit
  // are inverted (the sign*sign term stays positive).
  logic [PW-1:0] pp [0:NR0-1];

  generate
    for (gi = 0; gi < W; gi++) begin : g_pp
      logic [W-1:0] row;
      always_comb begin
        row = a_s & {W{b_s[gi]}};
        if (m_s) begin
          if (gi == W - 1) row[W-2:0] = ~row[W-2:0];
          else             row[W-1]   = ~row[W-1];
        end
      end
      assign pp[gi] = PW'(row) << gi;
    end
  endgenerate
  assign pp[W] = m_s ? BW_K : '0;

  // Reduction levels: each groups rows in threes into sum/carry pairs.
  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      localparam int NR = rows_at(gi);
      logic [PW-1:0] rows [0:NR-1];
      logic [TW-1:0] tag;
      if (gi == 0) begin : g_src
        always_comb begin
          for (int r = 0; r < NR; r++) rows[r] = pp[r];
        end
        assign tag = tag_s;
      end else begin : g_csa
        localparam int NIN = rows_at(gi - 1);
        localparam int NG  = NIN / 3;
        logic [PW-1:0] nxt [0:NR-1];
        always_comb begin
          for (int g = 0; g < NG; g++) begin
            nxt[2*g]   = g_lvl[gi-1].rows[3*g] ^ g_lvl[gi-1].rows[3*g+1]
                       ^ g_lvl[gi-1].rows[3*g+2];
            nxt[2*g+1] = ((g_lvl[gi-1].rows[3*g]   & g_lvl[gi-1].rows[3*g+1])
                        | (g_lvl[gi-1].rows[3*g]   & g_lvl[gi-1].rows[3*g+2])
                        | (g_lvl[gi-1].rows[3*g+1] & g_lvl[gi-1].rows[3*g+2])) << 1;
          end
          for (int k = 0; k < NIN % 3; k++) nxt[2*NG+k] = g_lvl[gi-1].rows[3*NG+k];
        end
        if (is_cut(gi)) begin : g_cut
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              for (int r = 0; r < NR; r++) rows[r] <= '0;
              tag <= '0;
            end else if (advance) begin
              for (int r = 0; r < NR; r++) rows[r] <= nxt[r];
              tag <= g_lvl[gi-1].tag;
            end
          end
        end else begin : g_pass
          always_comb begin
            for (int r = 0; r < NR; r++) rows[r] = nxt[r];
          end
          assign tag = g_lvl[gi-1].tag;
        end
      end
    end
  endgenerate

  logic [PW-1:0] product;
  logic [PW-1:0] result;
  logic          fin_valid;
  assign product   = g_lvl[L].rows[0] + g_lvl[L].rows[1];
  assign fin_valid = g_lvl[L].tag[0];

`ifdef WALLACE_ACC_EN
  logic [PW-1:0] acc;
  assign result = g_lvl[L].tag[1] ? (acc + product) : product;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       acc <= '0;
    else if (advance && fin_valid)    acc <= result;
  end
`else
  assign result = product;
`endif

  // prod only loads on a real result so it holds through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
    end else if (advance) begin
      out_valid <= fin_valid;
      if (fin_valid) prod <= result;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe
// Scoreboard bench: expected products are queued at input transfer and
// compared at output transfer. One line printed per transaction.
module tb_wallace_mult_pipe;

  localparam int W      = 8;
  localparam int STAGES = 2;

  logic           clk         = 1'b0;
  logic           rst_n       = 1'b0;
  logic           ena         = 1'b0;
  logic           in_valid    = 1'b0;
  logic           signed_mode = 1'b0;
  logic           out_ready   = 1'b0;
  logic [W-1:0]   a           = '0;
  logic [W-1:0]   b           = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] prod;
`ifdef WALLACE_ACC_EN
  logic           acc_en      = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  wallace_mult_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
`ifdef WALLACE_ACC_EN
    .acc_en     (acc_en),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .prod       (prod)
  );

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic signed [15:0] sp;
    if (s) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      sp = sx * sy;
      return sp;
    end
    return {8'h00, x} * {8'h00, y};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (prod !== 16'h0000) begin n_fail++; $display("FAIL reset_prod got=%h want=0000", prod); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    ena = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ena_low_in_ready got=%b want=0", in_ready); end
    ena = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_basic();
    @(negedge clk);
    a = 8'd13; b = 8'd11; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early got=%b want=0", out_valid); end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    n_checks++;
    if (prod !== 16'h008F) begin n_fail++; $display("FAIL basic_prod got=%h want=008f", prod); end
    $display("basic: 13*11 prod=%h", prod);
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_fall got=%b want=0", out_valid); end
  endtask

  // Corner products and mixed signed/unsigned ops streamed back to back.
  task automatic test_arith_table();
    logic [7:0]  ta [5] = '{8'hFF, 8'h80, 8'hFF, 8'hFE, 8'hFE};
    logic [7:0]  tb [5] = '{8'hFF, 8'h80, 8'h01, 8'h03, 8'h03};
    logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] te [5] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'hFFFA, 16'h02FA};
    logic [15:0] e;
    int idx = 0;
    int cyc = 0;
    ena = 1'b1; out_ready = 1'b1;
    while ((idx < 5 || exp_q.size() != 0) && cyc < 40) begin
      @(negedge clk);
      in_valid = (idx < 5);
      if (idx < 5) begin a = ta[idx]; b = tb[idx]; signed_mode = ts[idx]; end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL table_extra got=%h want=none", prod);
        end else begin
          e = exp_q.pop_front();
          if (prod !== e) begin n_fail++; $display("FAIL table_prod got=%h want=%h", prod, e); end
          else $display("table: prod=%h", prod);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(te[idx]); idx++; end
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || idx != 5) begin
      n_fail++; $display("FAIL table_timeout pending=%0d want=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    int pops = 0;
    ena = 1'b1; signed_mode = 1'b0;
    while ((idx < 4 || exp_q.size() != 0) && cyc < 40) begin
      @(negedge clk);
      in_valid  = (idx < 4);
      a         = 8'(idx + 1);
      b         = 8'(idx + 1);
      out_ready = !(out_valid && stall < 3);
      #1;
      if (!out_ready) begin
        stall++;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready got=%b want=0", in_ready); end
        n_checks++;
        if (prod !== 16'h0001) begin n_fail++; $display("FAIL b2b_stall_prod got=%h want=0001", prod); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        pops++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra got=%h want=none", prod);
        end else begin
          e = exp_q.pop_front();
          if (prod !== e) begin n_fail++; $display("FAIL b2b_prod got=%h want=%h", prod, e); end
          else $display("b2b: prod=%h", prod);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(16'((idx + 1) * (idx + 1))); idx++; end
      cyc++;
    end
    n_checks++;
    if (pops != 4 || stall != 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d/%0d want=4/3", pops, stall);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic        exp_rdy;
    int cyc = 0;
    while ((cyc < 300 || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      if (cyc < 300) begin
        ena         = ($urandom_range(0, 9) != 0);
        in_valid    = ($urandom_range(0, 2) != 0);
        out_ready   = ($urandom_range(0, 3) != 0);
        a           = 8'($urandom);
        b           = 8'($urandom);
        signed_mode = 1'($urandom);
      end else begin
        ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      exp_rdy = ena && !(out_valid && !out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready got=%b want=%b", in_ready, exp_rdy); end
      if (out_valid && out_ready && ena) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra got=%h want=none", prod);
        end else begin
          e = exp_q.pop_front();
          if (prod !== e) begin n_fail++; $display("FAIL rand_prod got=%h want=%h", prod, e); end
          else $display("rand: prod=%h", prod);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, signed_mode));
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout pending=%0d want=0", exp_q.size()); end
    exp_q.delete();
    ena = 1'b1;
  endtask

  task automatic test_mid_reset();
    ena = 1'b1; out_ready = 1'b1; signed_mode = 1'b0;
    @(negedge clk);
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd5; b = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight got=%b want=1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (prod !== 16'h0000) begin n_fail++; $display("FAIL midrst_prod got=%h want=0000", prod); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost got=%b want=0", out_valid); end
    end
    $display("midrst: no result after release");
  endtask

`ifdef WALLACE_ACC_EN
  task automatic test_acc();
    logic [7:0]  ta [3] = '{8'd3, 8'd5, 8'd2};
    logic [7:0]  tb [3] = '{8'd4, 8'd6, 8'd2};
    logic        tacc [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] te [3] = '{16'd12, 16'd42, 16'd4};
    logic [15:0] e;
    int idx = 0;
    int cyc = 0;
    out_ready = 1'b1; signed_mode = 1'b0;
    while ((idx < 3 || exp_q.size() != 0) && cyc < 40) begin
      @(negedge clk);
      ena      = !(cyc == 2 || cyc == 3);
      in_valid = (idx < 3);
      if (idx < 3) begin a = ta[idx]; b = tb[idx]; acc_en = tacc[idx]; end
      #1;
      if (out_valid && out_ready && ena) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL acc_extra got=%h want=none", prod);
        end else begin
          e = exp_q.pop_front();
          if (prod !== e) begin n_fail++; $display("FAIL acc_prod got=%h want=%h", prod, e); end
          else $display("acc: prod=%h", prod);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(te[idx]); idx++; end
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || idx != 3) begin
      n_fail++; $display("FAIL acc_timeout pending=%0d want=0", exp_q.size());
    end
    exp_q.delete();
    ena = 1'b1; acc_en = 1'b0; in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_arith_table();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef WALLACE_ACC_EN
    test_acc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier; successor to the fixed 8-bit combinational multiplier.
- Configurable operand width, register stages and signed/unsigned mode per operation.
- valid/ready handshake on both sides so it can sit between the tile I/O sequencer and downstream logic.
- Full-width 2W product; no truncation.

Parameters:
- W, 8, operand width in bits (4..16).
- STAGES, 2, pipeline register stages from accepted input to registered output (1..4). Stage 1 registers operands and mode. Later stages cut the reduction tree evenly; the final adder is in the last stage.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low freezes all state.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  output  1  prod holds a result.
- out_ready  input  1  consumer takes result this cycle.
- prod  output  2W  product, registered.
- acc_en  input  1  present only with WALLACE_ACC_EN; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, prod and internal pipeline data go to 0. in_ready is 0 while rst_n is low. After release, in_ready = ena.
- Definitions: advance = ena & ~(out_valid & ~out_ready); in_ready = advance.
- Transfer: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Global-stall pipeline: on advance, every stage shifts one step.
  - Stage 1 loads {in_valid & in_ready, a, b, signed_mode}.
  - Bubbles shift like data; there is no bubble collapse.
- Latency: a result accepted at edge k appears with out_valid=1 after edge k+STAGES-1, provided advance stays high. Throughput is one op per cycle.
- Stall: when out_valid & ~out_ready:
  - prod and out_valid hold.
  - in_ready is 0.
  - No stage changes.
  - Order is preserved and no result is lost or duplicated.
- ena low: identical to stall, regardless of out_ready. Nothing is accepted and all state holds.
- Arithmetic:
  - Unsigned mode: prod = a*b, exact in 2W bits.
  - Signed mode: Baugh-Wooley partial-product correction; prod = two's-complement a*b in 2W bits, exact for all inputs including (-2^(W-1))^2.
  - Each op uses its own sampled signed_mode; mixed modes in flight are legal.
- out_valid falls after an output transfer if the incoming final stage is a bubble.
- Mid-operation reset: all in-flight ops are discarded. No result emerges after release.
- a, b and signed_mode are don't-care when in_valid=0. prod is don't-care-free: it holds its last value when out_valid=0 after the first result, and is 0 from reset.

Optional Feature:
- Macro: WALLACE_ACC_EN.
- With the macro defined:
  - acc_en port exists and 2W-bit accumulator register acc exists; acc resets to 0.
  - acc_en is sampled with the operands.
  - On the final stage's output-load, if the op's acc_en=1: prod = acc + product, and acc gets that same sum.
  - If acc_en=0: prod = product and acc = product, which starts a new sum.
  - Sum wraps modulo 2^(2W), signed or unsigned alike.
  - acc holds during stall/ena low.
- Without the macro: no acc_en port, no accumulator, prod is the plain product.

Test Plan:
- W=8, STAGES=2, unsigned 13*11, out_ready=1 → prod=0x008F, out_valid high exactly one cycle after acceptance.
- Unsigned 255*255 → 0xFE01. Signed 0x80*0x80 → 0x4000. Signed 0xFF*0x01 → 0xFFFF.
- Back-to-back 1*1, 2*2, 3*3, 4*4 with out_ready=0 for 3 cycles after the first result:
  - in_ready low during the stall and prod held at 0x0001.
  - Then outputs 1,4,9,16 in order, none dropped.
- Mixed modes in flight: signed 0xFE*0x03 then unsigned 0xFE*0x03 → 0xFFFA then 0x02FA.
- rst_n pulsed low with two ops in flight → out_valid, prod = 0 immediately (asynchronous); no result after release.
- WALLACE_ACC_EN: 3*4 acc_en=0 then 5*6 acc_en=1 then 2*2 acc_en=0 → 12, 42, 4. ena low for 2 cycles mid-sequence leaves results unchanged.
